decode_stage: RTL and testbench
===============================

# decode_stage

Instruction-decode stage of the pipelined RV32I core, sitting directly upstream of the EX stage and wrapped around `RegisterFile`. It drives the register file read addresses from the instruction held in IF/ID and extracts the immediate and control bits. It detects load-use hazards and inserts bubbles, and it owns the ID/EX pipeline register. Writeback data is bypassed into the read path so a same-cycle register write is never read stale.

## Interface
- `XLEN`, 32: datapath width; only 32 is supported.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high; clears ID/EX.
- `if_valid` in 1: IF/ID holds a valid instruction.
- `if_instr` in 32: instruction word.
- `if_pc` in 32: PC of `if_instr`.
- `if_ready` out 1: instruction accepted this cycle; IF/ID must hold when low.
- `rf_addrA`, `rf_addrB` out 5: equal to `if_instr[19:15]` and `if_instr[24:20]`; combinational.
- `rf_dataA`, `rf_dataB` in 32: register file read data.
- `wb_reg_write` in 1, `wb_addrD` in 5, `wb_dataD` in 32: the same writeback bus that drives `RegisterFile`.
- `ex_stall` in 1: EX cannot accept; hold ID/EX.
- `flush` in 1: taken branch/jump resolved in EX; kill IF/ID and ID/EX contents.
- `ex_valid` out 1, `ex_pc` out 32, `ex_rs1_data` out 32, `ex_rs2_data` out 32, `ex_imm` out 32: ID/EX payload.
- `ex_rs1`, `ex_rs2`, `ex_rd` out 5: register indices, used for forwarding in EX.
- `ex_opcode` out 7, `ex_funct3` out 3, `ex_funct7b5` out 1: ALU decode fields.
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_illegal` out 1: control bits.

## Operation
- Source-use rules:
  - rs1 is used by every opcode except LUI (0110111), AUIPC (0010111) and JAL (1101111).
  - rs2 is used only by OP (0110011), STORE (0100011) and BRANCH (1100011).
- Immediate sign extension by opcode:
  - I-type: OP-IMM, LOAD, JALR.
  - S-type: STORE.
  - B-type: BRANCH.
  - U-type: LUI, AUIPC.
  - J-type: JAL.
  - OP uses imm = 0.
- Control bits:
  - `reg_write` = 1 for OP, OP-IMM, LOAD, JAL, JALR, LUI, AUIPC, and only when rd ≠ 0.
  - `mem_read` = 1 for LOAD; `mem_write` = 1 for STORE.
  - Any other opcode: `illegal` = 1 and all three control bits 0.
- Bypass: if `wb_reg_write` && `wb_addrD` ≠ 0 && `wb_addrD` == rs, the read data for that source is `wb_dataD`; otherwise it is `rf_data`. x0 always reads 0.
- Load-use hazard (`lu`): `if_valid` && `ex_valid` && `ex_mem_read` && `ex_rd` ≠ 0 && `ex_rd` matches a used source.
- `if_ready` = !`ex_stall` && !`lu`. The `flush` input does not lower it.
- ID/EX update priority per cycle:
  1. `reset`: clear all of ID/EX.
  2. `flush`: `ex_valid` ← 0, and the IF/ID instruction is discarded.
  3. `ex_stall`: hold all of ID/EX.
  4. `lu`: bubble; `ex_valid` ← 0 and control bits ← 0. Payload is don't-care.
  5. `if_valid`: load the decoded instruction with `ex_valid` ← 1.
  6. Otherwise: `ex_valid` ← 0.
- Whenever `ex_valid` is 0, the control bits are 0.

## Timing
- Reset value of every ID/EX output is 0, including `ex_valid`.
- `rf_addrA`/`rf_addrB`, the bypass path and `if_ready` are combinational from the inputs and ID/EX state.
- Latency: an instruction accepted at edge N appears on `ex_*` after edge N (one cycle).
- Load-use costs exactly one bubble cycle: the stalled instruction is accepted on the following cycle, with the load now in MEM.
- `reset` asserted mid-stall: ID/EX clears on that edge and `lu` deasserts on the next cycle.
- `flush` together with `lu` or `ex_stall`: `flush` wins.

## Configuration
- `DECODE_WB_BYPASS_EN` defined: the WB→decode bypass mux is present, as described above.
- `DECODE_WB_BYPASS_EN` undefined:
  - The mux is removed.
  - A WB source match (`wb_reg_write`, `wb_addrD` ≠ 0, `wb_addrD` == a used rs) also drops `if_ready` and inserts a bubble for one cycle.
  - The instruction then reads the committed value from the register file.

## Test plan
- Reset with `reset`=1 for 2 cycles → every `ex_*` output is 0. Then `if_valid`=1 with `addi x5,x0,-3` (0xFFD00293) → next cycle `ex_valid`=1, `ex_imm`=0xFFFFFFFD, `ex_rd`=5, `ex_reg_write`=1.
- Load-use: `lw x6,0(x1)` followed by `add x7,x6,x2` → `if_ready`=0 for exactly 1 cycle, one `ex_valid`=0 bubble, then the add is issued. `add x7,x0,x2` after the lw → no stall.
- WB bypass: `rf_dataA`=0x11111116, `wb_reg_write`=1, `wb_addrD`=5, `wb_dataD`=0xCAFEF00D, decode of `add x8,x5,x0` → `ex_rs1_data`=0xCAFEF00D. With the macro undefined → one bubble, then the register file value is used.
- x0 handling: WB to addr 0 with 0xDEADBEEF while decoding an instruction that reads x0 → data is 0. `add x0,x1,x2` → `ex_reg_write`=0.
- `flush` coinciding with a load-use stall and `ex_stall` → the next `ex_valid` is 0 and the held instruction is not issued.
- Immediate encodings:
  - `sw x2,-8(x3)` → `ex_imm`=0xFFFFFFF8, `ex_mem_write`=1.
  - `beq` with offset +16 → `ex_imm`=16.
  - `lui x1,0x12345` → `ex_imm`=0x12345000.
  - Opcode 0x7F → `ex_illegal`=1 with all other control bits 0.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: RV32I instruction decode, load-use/WB hazard bubbles, ID/EX pipeline register.
// Latency: an instruction accepted on edge N is presented on ex_* after edge N (one cycle).
// Backpressure: if_ready drops on ex_stall or a hazard; ex_stall holds ID/EX; flush kills IF/ID and ID/EX.
//
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset (clears ID/EX)
//   if_valid/if_instr/if_pc IF/ID contents; if_ready accepts the instruction this cycle
//   rf_addrA/B, rf_dataA/B  register file read port (addresses combinational from if_instr)
//   wb_reg_write/addrD/dataD writeback bus shared with the register file
//   ex_stall, flush         EX backpressure and taken-branch kill
//   ex_*                    ID/EX payload, register indices and control bits
//
// Build option: DECODE_WB_BYPASS_EN
//   defined   -> writeback data is muxed into the read path (no stall on a WB match)
//   undefined -> no mux; a WB match on a used source costs one bubble, then the
//                committed register file value is read

module decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [31:0]     if_pc,
  output logic            if_ready,
  output logic [4:0]      rf_addrA,
  output logic [4:0]      rf_addrB,
  input  logic [XLEN-1:0] rf_dataA,
  input  logic [XLEN-1:0] rf_dataB,
  input  logic            wb_reg_write,
  input  logic [4:0]      wb_addrD,
  input  logic [XLEN-1:0] wb_dataD,
  input  logic            ex_stall,
  input  logic            flush,
  output logic            ex_valid,
  output logic [31:0]     ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [31:0]     ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [6:0]      ex_opcode,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7b5,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef struct packed {
    logic            valid;
    logic [31:0]     pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [31:0]     imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            illegal;
  } idex_t;

  idex_t idex_q, idex_d, dec;

  logic [6:0]      opc;
  logic [4:0]      rs1, rs2, rd;
  logic            use_rs1, use_rs2;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic            lu, wb_hz, hazard;

  assign opc      = if_instr[6:0];
  assign rd       = if_instr[11:7];
  assign rs1      = if_instr[19:15];
  assign rs2      = if_instr[24:20];
  assign rf_addrA = rs1;
  assign rf_addrB = rs2;

  // Field decode: immediate format, source usage and control bits.
  always_comb begin
    dec          = '0;
    dec.valid    = 1'b1;
    dec.pc       = if_pc;
    dec.rs1      = rs1;
    dec.rs2      = rs2;
    dec.rd       = rd;
    dec.opcode   = opc;
    dec.funct3   = if_instr[14:12];
    dec.funct7b5 = if_instr[30];
    use_rs1      = 1'b1;
    use_rs2      = 1'b0;
    case (opc)
      OPC_OP: begin
        use_rs2       = 1'b1;
        dec.reg_write = 1'b1;
      end
      OPC_OPIMM, OPC_JALR: begin
        dec.imm       = {{20{if_instr[31]}}, if_instr[31:20]};
        dec.reg_write = 1'b1;
      end
      OPC_LOAD: begin
        dec.imm       = {{20{if_instr[31]}}, if_instr[31:20]};
        dec.reg_write = 1'b1;
        dec.mem_read  = 1'b1;
      end
      OPC_STORE: begin
        dec.imm       = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
        use_rs2       = 1'b1;
        dec.mem_write = 1'b1;
      end
      OPC_BRANCH: begin
        dec.imm = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                   if_instr[30:25], if_instr[11:8], 1'b0};
        use_rs2 = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        dec.imm       = {if_instr[31:12], 12'b0};
        use_rs1       = 1'b0;
        dec.reg_write = 1'b1;
      end
      OPC_JAL: begin
        dec.imm = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                   if_instr[20], if_instr[30:21], 1'b0};
        use_rs1       = 1'b0;
        dec.reg_write = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    // Writes to x0 are architecturally discarded; never advertise them to EX.
    if (rd == 5'd0) dec.reg_write = 1'b0;
    dec.rs1_data = rs1_data;
    dec.rs2_data = rs2_data;
  end

`ifdef DECODE_WB_BYPASS_EN
  // A non-zero rs that equals wb_addrD already implies wb_addrD != 0.
  assign rs1_data = (rs1 == 5'd0) ? '0 :
                    (wb_reg_write && (wb_addrD == rs1)) ? wb_dataD : rf_dataA;
  assign rs2_data = (rs2 == 5'd0) ? '0 :
                    (wb_reg_write && (wb_addrD == rs2)) ? wb_dataD : rf_dataB;
  assign wb_hz    = 1'b0;
`else
  logic unused_wb_data;
  assign unused_wb_data = ^wb_dataD;
  assign rs1_data = (rs1 == 5'd0) ? '0 : rf_dataA;
  assign rs2_data = (rs2 == 5'd0) ? '0 : rf_dataB;
  // Without the bypass the same-cycle write is not yet visible; wait one cycle.
  assign wb_hz    = if_valid && wb_reg_write && (wb_addrD != 5'd0) &&
                    ((use_rs1 && (wb_addrD == rs1)) || (use_rs2 && (wb_addrD == rs2)));
`endif

  assign lu = if_valid && idex_q.valid && idex_q.mem_read && (idex_q.rd != 5'd0) &&
              ((use_rs1 && (idex_q.rd == rs1)) || (use_rs2 && (idex_q.rd == rs2)));

  assign hazard   = lu || wb_hz;
  assign if_ready = !ex_stall && !hazard;

  // ID/EX next state. Control bits are cleared with valid so an invalid slot
  // can never be mistaken for a register write or memory access downstream.
  always_comb begin
    idex_d = idex_q;
    if (flush || (!ex_stall && (hazard || !if_valid))) begin
      idex_d.valid     = 1'b0;
      idex_d.reg_write = 1'b0;
      idex_d.mem_read  = 1'b0;
      idex_d.mem_write = 1'b0;
      idex_d.illegal   = 1'b0;
    end else if (!ex_stall) begin
      idex_d = dec;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) idex_q <= '0;
    else       idex_q <= idex_d;
  end

  assign ex_valid     = idex_q.valid;
  assign ex_pc        = idex_q.pc;
  assign ex_rs1_data  = idex_q.rs1_data;
  assign ex_rs2_data  = idex_q.rs2_data;
  assign ex_imm       = idex_q.imm;
  assign ex_rs1       = idex_q.rs1;
  assign ex_rs2       = idex_q.rs2;
  assign ex_rd        = idex_q.rd;
  assign ex_opcode    = idex_q.opcode;
  assign ex_funct3    = idex_q.funct3;
  assign ex_funct7b5  = idex_q.funct7b5;
  assign ex_reg_write = idex_q.reg_write;
  assign ex_mem_read  = idex_q.mem_read;
  assign ex_mem_write = idex_q.mem_write;
  assign ex_illegal   = idex_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed scenarios plus a randomized run against a behavioural model.
// Latency: checks registered outputs #1 after each rising edge, combinational ones before the next.
// Backpressure: the bench plays IF, holding IF/ID whenever the model says the instruction was refused.

module tb_decode_stage;

`ifdef DECODE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam logic [6:0] OP = 7'h33, OPIMM = 7'h13, LOAD = 7'h03, STORE = 7'h23, BRANCH = 7'h63;
  localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6F, JALR = 7'h67;

  localparam logic [31:0] I_LW_X6     = 32'h0000A303;  // lw   x6,0(x1)
  localparam logic [31:0] I_ADD_DEP   = 32'h002303B3;  // add  x7,x6,x2
  localparam logic [31:0] I_ADD_X0    = 32'h002003B3;  // add  x7,x0,x2
  localparam logic [31:0] I_ADD_X8_X5 = 32'h00028433;  // add  x8,x5,x0
  localparam logic [31:0] I_ADDI_X9   = 32'h00100493;  // addi x9,x0,1
  localparam logic [31:0] I_ADD_RD0   = 32'h00208033;  // add  x0,x1,x2

  logic        clk = 1'b0;
  logic        reset, if_valid, if_ready, wb_reg_write, ex_stall, flush;
  logic [31:0] if_instr, if_pc, rf_dataA, rf_dataB, wb_dataD;
  logic [4:0]  rf_addrA, rf_addrB, wb_addrD;
  logic        ex_valid, ex_funct7b5, ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_ready(if_ready), .rf_addrA(rf_addrA), .rf_addrB(rf_addrB),
    .rf_dataA(rf_dataA), .rf_dataB(rf_dataB), .wb_reg_write(wb_reg_write),
    .wb_addrD(wb_addrD), .wb_dataD(wb_dataD), .ex_stall(ex_stall), .flush(flush),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_opcode(ex_opcode),
    .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_illegal(ex_illegal)
  );

  // ---------------- behavioural reference ----------------
  typedef struct {
    bit          valid;
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f7;
    bit          rw, mr, mw, ill;
  } exm_t;

  exm_t m;

  // Immediate value assembled arithmetically: sign term plus weighted bit fields.
  function automatic int ref_imm(input logic [31:0] ins);
    int sgn;
    case (ins[6:0])
      OPIMM, LOAD, JALR: begin
        sgn = ins[31] ? -2048 : 0;
        return sgn + int'(ins[30:20]);
      end
      STORE: begin
        sgn = ins[31] ? -2048 : 0;
        return sgn + int'(ins[30:25]) * 32 + int'(ins[11:7]);
      end
      BRANCH: begin
        sgn = ins[31] ? -4096 : 0;
        return sgn + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
      end
      LUI, AUIPC: return int'(ins[31:12]) * 4096;
      JAL: begin
        sgn = ins[31] ? -1048576 : 0;
        return sgn + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
      end
      default: return 0;
    endcase
  endfunction

  function automatic bit reads_reg(input logic [31:0] ins, input logic [4:0] r);
    bit u1, u2;
    u1 = !(ins[6:0] inside {LUI, AUIPC, JAL});
    u2 = ins[6:0] inside {OP, STORE, BRANCH};
    return (u1 && ins[19:15] == r) || (u2 && ins[24:20] == r);
  endfunction

  function automatic logic [31:0] src_val(input logic [4:0] rs, input logic [31:0] rf,
                                          input bit wbe, input logic [4:0] wba,
                                          input logic [31:0] wbd);
    if (rs == 0) return 32'h0;
    if (BYP && wbe && wba == rs) return wbd;
    return rf;
  endfunction

  function automatic exm_t ref_decode(input logic [31:0] ins, pc, rfa, rfb,
                                      input bit wbe, input logic [4:0] wba,
                                      input logic [31:0] wbd);
    exm_t r;
    r.valid = 1;
    r.pc  = pc;
    r.rs1 = ins[19:15];
    r.rs2 = ins[24:20];
    r.rd  = ins[11:7];
    r.opc = ins[6:0];
    r.f3  = ins[14:12];
    r.f7  = ins[30];
    r.imm = ref_imm(ins);
    r.d1  = src_val(r.rs1, rfa, wbe, wba, wbd);
    r.d2  = src_val(r.rs2, rfb, wbe, wba, wbd);
    r.ill = !(r.opc inside {OP, OPIMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR});
    r.mr  = (r.opc == LOAD);
    r.mw  = (r.opc == STORE);
    r.rw  = (r.opc inside {OP, OPIMM, LOAD, JAL, JALR, LUI, AUIPC}) && (r.rd != 0);
    return r;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [6:0] o;
    case ($urandom_range(0, 11))
      0: o = OP;      1: o = OPIMM;  2: o = LOAD;   3: o = LOAD;
      4: o = STORE;   5: o = BRANCH; 6: o = LUI;    7: o = AUIPC;
      8: o = JAL;     9: o = JALR;   10: o = 7'h73; default: o = 7'h7F;
    endcase
    // Registers drawn from x0..x3 so hazards and x0 cases occur often.
    return {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            3'($urandom), 5'($urandom_range(0, 3)), o};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1; if_valid = 0; if_instr = 0; if_pc = 0; rf_dataA = 0; rf_dataB = 0;
    wb_reg_write = 0; wb_addrD = 0; wb_dataD = 0; ex_stall = 0; flush = 0;
    tick(); tick();
    tests++; if (ex_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", ex_valid); end
    tests++;
    if ({ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_opcode, ex_funct3,
         ex_funct7b5, ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal} !== '0) begin
      fails++; $display("FAIL reset_payload: ex_pc=%h ex_imm=%h ex_rd=%0d not all zero", ex_pc, ex_imm, ex_rd);
    end
    tests++; if (if_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", if_ready); end
  endtask

  task automatic test_addi();
    reset = 0; if_valid = 1; if_instr = 32'hFFD00293; if_pc = 32'h100; rf_dataA = 32'h12345678;
    #1;
    tests++; if (rf_addrA !== 5'd0 || if_ready !== 1'b1) begin
      fails++; $display("FAIL addi_comb: addrA=%0d ready=%b want 0/1", rf_addrA, if_ready); end
    tick();
    tests++; if (ex_valid !== 1'b1) begin fails++; $display("FAIL addi_valid: got %b want 1", ex_valid); end
    tests++; if (ex_imm !== 32'hFFFFFFFD) begin fails++; $display("FAIL addi_imm: got %h want fffffffd", ex_imm); end
    tests++; if (ex_rd !== 5'd5 || ex_reg_write !== 1'b1) begin
      fails++; $display("FAIL addi_rd: rd=%0d rw=%b want 5/1", ex_rd, ex_reg_write); end
    tests++; if (ex_rs1_data !== 32'h0 || ex_pc !== 32'h100) begin
      fails++; $display("FAIL addi_data: rs1_data=%h pc=%h want 0/100", ex_rs1_data, ex_pc); end
    if_valid = 0;
    tick();
    tests++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin
      fails++; $display("FAIL idle_bubble: valid=%b rw=%b want 0/0", ex_valid, ex_reg_write); end
  endtask

  task automatic test_load_use();
    if_valid = 1; if_instr = I_LW_X6;
    tick();
    if_instr = I_ADD_DEP; #1;
    tests++; if (if_ready !== 1'b0) begin fails++; $display("FAIL lu_stall: ready=%b want 0", if_ready); end
    tick();
    tests++; if (ex_valid !== 1'b0 || ex_mem_read !== 1'b0) begin
      fails++; $display("FAIL lu_bubble: valid=%b mr=%b want 0/0", ex_valid, ex_mem_read); end
    tests++; if (if_ready !== 1'b1) begin fails++; $display("FAIL lu_release: ready=%b want 1", if_ready); end
    tick();
    tests++; if (ex_valid !== 1'b1 || ex_rd !== 5'd7 || ex_rs1 !== 5'd6) begin
      fails++; $display("FAIL lu_issue: valid=%b rd=%0d rs1=%0d want 1/7/6", ex_valid, ex_rd, ex_rs1); end
    if_instr = I_LW_X6;
    tick();
    if_instr = I_ADD_X0; #1;
    tests++; if (if_ready !== 1'b1) begin fails++; $display("FAIL lu_none: ready=%b want 1", if_ready); end
    tick();
    tests++; if (ex_valid !== 1'b1 || ex_rs2 !== 5'd2) begin
      fails++; $display("FAIL lu_none_issue: valid=%b rs2=%0d want 1/2", ex_valid, ex_rs2); end
    // Reset arriving while a load-use stall is pending.
    if_instr = I_LW_X6;
    tick();
    if_instr = I_ADD_DEP; reset = 1;
    tick();
    reset = 0; #1;
    tests++; if (ex_valid !== 1'b0 || if_ready !== 1'b1) begin
      fails++; $display("FAIL lu_reset: valid=%b ready=%b want 0/1", ex_valid, if_ready); end
    if_valid = 0;
    tick();
  endtask

  task automatic test_bypass();
    if_valid = 1; if_instr = I_ADD_X8_X5; rf_dataA = 32'h11111116;
    wb_reg_write = 1; wb_addrD = 5'd5; wb_dataD = 32'hCAFEF00D;
`ifdef DECODE_WB_BYPASS_EN
    #1;
    tests++; if (if_ready !== 1'b1) begin fails++; $display("FAIL byp_ready: ready=%b want 1", if_ready); end
    tick();
`else
    #1;
    tests++; if (if_ready !== 1'b0) begin fails++; $display("FAIL wbh_stall: ready=%b want 0", if_ready); end
    tick();
    tests++; if (ex_valid !== 1'b0) begin fails++; $display("FAIL wbh_bubble: valid=%b want 0", ex_valid); end
    wb_reg_write = 0; rf_dataA = 32'hCAFEF00D;  // value now committed in the register file
    tick();
`endif
    tests++; if (ex_valid !== 1'b1 || ex_rs1_data !== 32'hCAFEF00D) begin
      fails++; $display("FAIL byp_data: valid=%b rs1_data=%h want 1/cafef00d", ex_valid, ex_rs1_data); end
    wb_reg_write = 0; if_valid = 0;
    tick();
  endtask

  task automatic test_x0();
    if_valid = 1; if_instr = I_ADDI_X9; rf_dataA = 32'hDEADBEEF; rf_dataB = 32'hDEADBEEF;
    wb_reg_write = 1; wb_addrD = 5'd0; wb_dataD = 32'hDEADBEEF;
    #1;
    tests++; if (if_ready !== 1'b1) begin fails++; $display("FAIL x0_ready: ready=%b want 1", if_ready); end
    tick();
    tests++; if (ex_rs1_data !== 32'h0 || ex_imm !== 32'h1) begin
      fails++; $display("FAIL x0_data: rs1_data=%h imm=%h want 0/1", ex_rs1_data, ex_imm); end
    wb_reg_write = 0; if_instr = I_ADD_RD0;
    tick();
    tests++; if (ex_valid !== 1'b1 || ex_reg_write !== 1'b0 || ex_illegal !== 1'b0) begin
      fails++; $display("FAIL x0_rd: valid=%b rw=%b ill=%b want 1/0/0", ex_valid, ex_reg_write, ex_illegal); end
    if_valid = 0;
    tick();
  endtask

  task automatic test_stall();
    if_valid = 1; if_instr = I_ADDI_X9; if_pc = 32'h200;
    tick();
    if_instr = 32'h123450B7; if_pc = 32'h204; ex_stall = 1; #1;
    tests++; if (if_ready !== 1'b0) begin fails++; $display("FAIL stall_ready: ready=%b want 0", if_ready); end
    tick();
    tests++; if (ex_valid !== 1'b1 || ex_pc !== 32'h200) begin
      fails++; $display("FAIL stall_hold: valid=%b pc=%h want 1/200", ex_valid, ex_pc); end
    ex_stall = 0;
    tick();
    tests++; if (ex_pc !== 32'h204 || ex_imm !== 32'h12345000) begin
      fails++; $display("FAIL stall_release: pc=%h imm=%h want 204/12345000", ex_pc, ex_imm); end
    if_valid = 0;
    tick();
  endtask

  task automatic test_flush();
    if_valid = 1; if_instr = I_LW_X6;
    tick();
    if_instr = I_ADD_DEP; ex_stall = 1; flush = 1; #1;
    tests++; if (if_ready !== 1'b0) begin fails++; $display("FAIL flush_ready: ready=%b want 0", if_ready); end
    tick();
    tests++; if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal} !== 5'b0) begin
      fails++; $display("FAIL flush_kill: valid=%b mr=%b want 0/0", ex_valid, ex_mem_read); end
    flush = 0; ex_stall = 0; if_valid = 0;
    tick();
    tests++; if (ex_valid !== 1'b0) begin fails++; $display("FAIL flush_noissue: valid=%b want 0", ex_valid); end
  endtask

  task automatic test_imm();
    logic [31:0] ins [4] = '{32'hFE21AC23, 32'h00000863, 32'h123450B7, 32'h0000057F};
    logic [31:0] imm [4] = '{32'hFFFFFFF8, 32'h00000010, 32'h12345000, 32'h00000000};
    logic [3:0]  ctl [4] = '{4'b0010, 4'b0000, 4'b1000, 4'b0001};  // {rw, mr, mw, ill}
    for (int i = 0; i < 4; i++) begin
      if_valid = 1; if_instr = ins[i];
      tick();
      tests++; if (ex_imm !== imm[i]) begin
        fails++; $display("FAIL imm_%0d: got %h want %h", i, ex_imm, imm[i]); end
      tests++; if ({ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal} !== ctl[i]) begin
        fails++; $display("FAIL ctl_%0d: got %b want %b", i,
                          {ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal}, ctl[i]); end
    end
    if_valid = 0;
    tick();
  endtask

  task automatic test_random();
    logic [31:0] cur;
    bit held, lu, wbh, rdy;
    exm_t nxt;
    held = 0; cur = 0;
    reset = 1;
    tick();
    reset = 0;
    m = '{default: 0};
    for (int c = 0; c < 3000; c++) begin
      if (!held) begin cur = gen_instr(); if_pc = $urandom; end
      if_valid = held || ($urandom_range(0, 7) != 0);
      if_instr = cur;
      rf_dataA = $urandom; rf_dataB = $urandom;
      wb_reg_write = 1'($urandom_range(0, 1)); wb_addrD = 5'($urandom_range(0, 3)); wb_dataD = $urandom;
      ex_stall = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 9) == 0);
      lu  = if_valid && m.valid && m.mr && m.rd != 0 && reads_reg(cur, m.rd);
      wbh = !BYP && if_valid && wb_reg_write && wb_addrD != 0 && reads_reg(cur, wb_addrD);
      rdy = !ex_stall && !lu && !wbh;
      nxt = m;
      if (flush || (!ex_stall && (lu || wbh || !if_valid))) begin
        nxt.valid = 0; nxt.rw = 0; nxt.mr = 0; nxt.mw = 0; nxt.ill = 0;
      end else if (!ex_stall) begin
        nxt = ref_decode(cur, if_pc, rf_dataA, rf_dataB, wb_reg_write, wb_addrD, wb_dataD);
      end
      held = if_valid && !rdy && !flush;
      #1;
      tests++; if (if_ready !== rdy) begin
        fails++; $display("FAIL rnd_ready c=%0d: got %b want %b", c, if_ready, rdy); end
      tests++; if ({rf_addrA, rf_addrB} !== {cur[19:15], cur[24:20]}) begin
        fails++; $display("FAIL rnd_addr c=%0d: got %0d/%0d want %0d/%0d", c, rf_addrA, rf_addrB,
                          cur[19:15], cur[24:20]); end
      tick();
      m = nxt;
      tests++; if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal} !==
                   {m.valid, m.rw, m.mr, m.mw, m.ill}) begin
        fails++; $display("FAIL rnd_ctl c=%0d: got %b want %b", c,
                          {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal},
                          {m.valid, m.rw, m.mr, m.mw, m.ill}); end
      if (m.valid) begin
        tests++; if (ex_imm !== m.imm) begin
          fails++; $display("FAIL rnd_imm c=%0d: got %h want %h (op %h)", c, ex_imm, m.imm, m.opc); end
        tests++; if ({ex_rs1_data, ex_rs2_data} !== {m.d1, m.d2}) begin
          fails++; $display("FAIL rnd_data c=%0d: got %h/%h want %h/%h", c, ex_rs1_data, ex_rs2_data,
                            m.d1, m.d2); end
        tests++; if ({ex_pc, ex_rs1, ex_rs2, ex_rd, ex_opcode, ex_funct3, ex_funct7b5} !==
                     {m.pc, m.rs1, m.rs2, m.rd, m.opc, m.f3, m.f7}) begin
          fails++; $display("FAIL rnd_fields c=%0d: pc=%h rd=%0d op=%h want pc=%h rd=%0d op=%h",
                            c, ex_pc, ex_rd, ex_opcode, m.pc, m.rd, m.opc); end
      end
    end
    if_valid = 0; ex_stall = 0; flush = 0; wb_reg_write = 0;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load_use();
    test_bypass();
    test_x0();
    test_stall();
    test_flush();
    test_imm();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
